fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, address of first instruction after reset.
REQ-002 SHALL have parameter REG_BASE, default 32'h100, register-file base address driven on base_addr.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for any handshake.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr  output  32  instruction fetch address.
REQ-007 SHALL have port data  input  32  instruction word from bus.
REQ-008 SHALL have port read_q  output  1  one-cycle read request.
REQ-009 SHALL have port read_dn  input  1  read complete, data valid this cycle.
REQ-010 SHALL have port is_bus_busy  input  1  bus owned by another master.
REQ-011 SHALL have port state  output  4  sequencer state presented to operand/memory stage.
REQ-012 SHALL have port command_word  output  32  latched instruction.
REQ-013 SHALL have port base_addr  output  32  register-file base.
REQ-014 SHALL have port next_state  input  1  stage done; only 1'b1 counts, 0/z ignored.
REQ-015 SHALL have port cond  input  32  condition operand returned by memory stage.
REQ-016 SHALL have port exec_done  input  1  execute unit done pulse.
REQ-017 SHALL have port pc  output  32  current program counter.
REQ-018 SHALL have port halted  output  1  high in ST_HALT.
REQ-019 SHALL have port err  output  1  high in ST_ERR.

Function
REQ-020 SHALL implement states ST_IDLE, ST_BASE_ADDR_SET, ST_FETCH, ST_FETCH_WAIT, ST_READ_DATA, ST_EXECUTE, ST_WRITE_DATA, ST_HALT, ST_ERR; state output equals current state code.
REQ-021 SHALL go ST_IDLE -> ST_BASE_ADDR_SET one cycle after rst deasserts, drive base_addr=REG_BASE, and move to ST_FETCH on next_state==1.
REQ-022 SHALL, in ST_FETCH, drive addr=pc and pulse read_q for exactly one cycle when is_bus_busy!=1, then enter ST_FETCH_WAIT; while is_bus_busy==1 SHALL hold without read_q.
REQ-023 SHALL, in ST_FETCH_WAIT on read_dn==1, latch command_word=data, set pc=pc+4 (mod 2^32, wrap to 0), and enter ST_READ_DATA next cycle.
REQ-024 SHALL enter ST_HALT instead of ST_READ_DATA when latched data[31:28]==4'hF; pc still increments.
REQ-025 SHALL hold ST_READ_DATA until next_state==1; then enter ST_EXECUTE if cond!=0, else ST_FETCH (instruction skipped).
REQ-026 SHALL hold ST_EXECUTE until exec_done==1, then enter ST_WRITE_DATA.
REQ-027 SHALL hold ST_WRITE_DATA until next_state==1, then enter ST_FETCH.
REQ-028 SHALL keep command_word stable from latch until next read_dn in ST_FETCH_WAIT.
REQ-029 SHALL count cycles spent in any wait state (FETCH incl. busy, FETCH_WAIT, BASE_ADDR_SET, READ_DATA, EXECUTE, WRITE_DATA), clearing on every state change; count reaching TIMEOUT SHALL enter ST_ERR.
REQ-030 SHALL ignore read_dn outside ST_FETCH_WAIT and next_state/exec_done outside their wait states.
REQ-031 SHALL remain in ST_HALT or ST_ERR until rst; halted/err are registered, asserted the cycle the state is entered.
REQ-032 SHALL give read_dn and the timeout on the same cycle priority to read_dn.

Reset
REQ-033 SHALL on rst, regardless of state, set state=ST_IDLE, pc=RESET_PC, addr=0, read_q=0, command_word=0, base_addr=0, halted=0, err=0, wait counter=0, abandoning any outstanding fetch.
REQ-034 SHALL ignore a read_dn arriving in the first cycle after rst deasserts.

Structure
REQ-035 SHALL take the 4-bit state encodings and STATE_SIZE0 from the shared states include also used by the memory stage; opcode HALT (4'hF) and field positions in the shared sizes include.
REQ-036 SHALL be one module with an internal wait-counter block; no sub-modules.

Verification
REQ-037 SHALL test reset flow: rst 2 cycles, next_state=1 at cycle 3 -> state BASE_ADDR_SET, base_addr=32'h100, then FETCH with addr=0, one read_q pulse.
REQ-038 SHALL test full instruction: data=32'h0000_0123 with read_dn, cond=1, next_state, exec_done, next_state -> command_word=32'h123, pc=4, state returns to FETCH with addr=4.
REQ-039 SHALL test skip: cond=0 at READ_DATA done -> EXECUTE never entered, next fetch at pc+4.
REQ-040 SHALL test bus busy: is_bus_busy=1 for 5 cycles in FETCH -> read_q stays 0, single pulse on cycle busy drops.
REQ-041 SHALL test halt and wrap: RESET_PC=32'hFFFF_FFFC, data=32'hF000_0000 -> pc=0, halted=1, state ST_HALT held.
REQ-042 SHALL test timeout and mid-op reset: no read_dn for 255 cycles -> err=1; rst in FETCH_WAIT -> ST_IDLE, late read_dn ignored.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared sequencer definitions: state codes, state width,
// opcode field position and the HALT opcode.
package fetch_sequencer_pkg;

   localparam int STATE_SIZE0 = 4;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 28;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [STATE_SIZE0-1:0] {
      ST_IDLE          = 4'd0,
      ST_BASE_ADDR_SET = 4'd1,
      ST_FETCH         = 4'd2,
      ST_FETCH_WAIT    = 4'd3,
      ST_READ_DATA     = 4'd4,
      ST_EXECUTE       = 4'd5,
      ST_WRITE_DATA    = 4'd6,
      ST_HALT          = 4'd7,
      ST_ERR           = 4'd8
   } state_t;

   // States in which the sequencer waits on an external event
   // and therefore runs the timeout counter.
   function automatic logic is_wait(input state_t s);
      return (s == ST_BASE_ADDR_SET) || (s == ST_FETCH) ||
             (s == ST_FETCH_WAIT) || (s == ST_READ_DATA) ||
             (s == ST_EXECUTE) || (s == ST_WRITE_DATA);
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word, hands it to the
// operand/memory stage, waits for execute and write-back.
// Ports: clk/rst (sync, active-high); bus side addr, data,
// read_q, read_dn, is_bus_busy; stage side state, command_word,
// base_addr, next_state, cond, exec_done; status pc, halted, err.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] REG_BASE = 32'h100,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] addr,
   input  logic [31:0] data,
   output logic        read_q,
   input  logic        read_dn,
   input  logic        is_bus_busy,
   output logic [3:0]  state,
   output logic [31:0] command_word,
   output logic [31:0] base_addr,
   input  logic        next_state,
   input  logic [31:0] cond,
   input  logic        exec_done,
   output logic [31:0] pc,
   output logic        halted,
   output logic        err
);

   localparam int unsigned CW =
      (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t cur_st;
   state_t st_nxt;

   logic [CW-1:0] wait_cnt;
   logic          stage_go;
   logic          exec_go;
   logic          rd_go;
   logic          bus_free;
   logic          tmo;
   logic          is_halt_op;

   // Only a driven 1 counts; 0, x and z are all "not yet".
   assign stage_go = (next_state === 1'b1);
   assign exec_go  = (exec_done === 1'b1);
   assign rd_go    = (read_dn === 1'b1);
   assign bus_free = !(is_bus_busy === 1'b1);

   // Last cycle of the allowed wait in the current state.
   assign tmo = (wait_cnt == CW'(TIMEOUT - 1));

   assign is_halt_op = (data[OPC_MSB:OPC_LSB] == OPC_HALT);

   assign state = cur_st;

   always_comb begin
      st_nxt = cur_st;
      read_q = 1'b0;
      case (cur_st)
         ST_IDLE: st_nxt = ST_BASE_ADDR_SET;
         ST_BASE_ADDR_SET: begin
            if (stage_go)
               st_nxt = ST_FETCH;
            else if (tmo)
               st_nxt = ST_ERR;
         end
         ST_FETCH: begin
            if (bus_free) begin
               read_q = !rst;
               st_nxt = ST_FETCH_WAIT;
            end else if (tmo) begin
               st_nxt = ST_ERR;
            end
         end
         // read_dn wins over an expiring timeout.
         ST_FETCH_WAIT: begin
            if (rd_go)
               st_nxt = is_halt_op ? ST_HALT : ST_READ_DATA;
            else if (tmo)
               st_nxt = ST_ERR;
         end
         ST_READ_DATA: begin
            if (stage_go)
               st_nxt = (cond != 32'd0) ? ST_EXECUTE : ST_FETCH;
            else if (tmo)
               st_nxt = ST_ERR;
         end
         ST_EXECUTE: begin
            if (exec_go)
               st_nxt = ST_WRITE_DATA;
            else if (tmo)
               st_nxt = ST_ERR;
         end
         ST_WRITE_DATA: begin
            if (stage_go)
               st_nxt = ST_FETCH;
            else if (tmo)
               st_nxt = ST_ERR;
         end
         ST_HALT: st_nxt = ST_HALT;
         ST_ERR:  st_nxt = ST_ERR;
         default: st_nxt = ST_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_st       <= ST_IDLE;
         pc           <= RESET_PC;
         addr         <= 32'd0;
         command_word <= 32'd0;
         base_addr    <= 32'd0;
         halted       <= 1'b0;
         err          <= 1'b0;
      end else begin
         cur_st <= st_nxt;
         halted <= (st_nxt == ST_HALT);
         err    <= (st_nxt == ST_ERR);
         if (st_nxt == ST_BASE_ADDR_SET)
            base_addr <= REG_BASE;
         // addr tracks pc while fetching and holds during the wait.
         if (st_nxt == ST_FETCH)
            addr <= pc;
         if (cur_st == ST_FETCH_WAIT && rd_go) begin
            command_word <= data;
            pc           <= pc + 32'd4;
         end
      end
   end

   // Wait counter: cycles already spent in the current wait state.
   always_ff @(posedge clk) begin
      if (rst)
         wait_cnt <= '0;
      else if (st_nxt != cur_st)
         wait_cnt <= '0;
      else if (is_wait(cur_st))
         wait_cnt <= wait_cnt + CW'(1);
      else
         wait_cnt <= '0;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized bench for fetch_sequencer with a
// small pc/command model; second instance covers pc wrap.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data;
   logic        read_dn;
   logic        is_bus_busy;
   logic        next_state;
   logic [31:0] cond;
   logic        exec_done;
   logic [31:0] addr;
   logic        read_q;
   logic [3:0]  state;
   logic [31:0] command_word;
   logic [31:0] base_addr;
   logic [31:0] pc;
   logic        halted;
   logic        err;

   logic        w_rst;
   logic [31:0] w_data;
   logic        w_read_dn;
   logic        w_busy;
   logic        w_next;
   logic [31:0] w_cond;
   logic        w_exec;
   logic [31:0] w_addr;
   logic        w_read_q;
   logic [3:0]  w_state;
   logic [31:0] w_cmd;
   logic [31:0] w_base;
   logic [31:0] w_pc;
   logic        w_halted;
   logic        w_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   logic [31:0] m_cmd;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data),
      .read_q(read_q), .read_dn(read_dn),
      .is_bus_busy(is_bus_busy), .state(state),
      .command_word(command_word), .base_addr(base_addr),
      .next_state(next_state), .cond(cond),
      .exec_done(exec_done), .pc(pc), .halted(halted),
      .err(err)
   );

   fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst(w_rst), .addr(w_addr), .data(w_data),
      .read_q(w_read_q), .read_dn(w_read_dn),
      .is_bus_busy(w_busy), .state(w_state),
      .command_word(w_cmd), .base_addr(w_base),
      .next_state(w_next), .cond(w_cond),
      .exec_done(w_exec), .pc(w_pc), .halted(w_halted),
      .err(w_err)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:28] == 4'hF)
         w[31] = 1'b0;
      return w;
   endfunction

   // One instruction starting in FETCH: busy_n busy cycles,
   // fw_n idle cycles in FETCH_WAIT, then the full handshake.
   task automatic fetch_one(input logic [31:0] word,
                            input logic take,
                            input int busy_n,
                            input int fw_n);
      chk("fetch_state", 32'(state), 32'(ST_FETCH));
      chk("fetch_addr", addr, m_pc);
      for (int i = 0; i < busy_n; i++) begin
         is_bus_busy = 1'b1;
         #1;
         chk("busy_no_req", 32'(read_q), 32'd0);
         step;
         chk("busy_hold", 32'(state), 32'(ST_FETCH));
      end
      is_bus_busy = 1'b0;
      #1;
      chk("req_pulse", 32'(read_q), 32'd1);
      step;
      chk("req_end", 32'(read_q), 32'd0);
      chk("fw_state", 32'(state), 32'(ST_FETCH_WAIT));
      for (int i = 0; i < fw_n; i++) begin
         next_state = 1'b1;
         exec_done = 1'b1;
         step;
      end
      next_state = 1'b0;
      exec_done = 1'b0;
      chk("fw_wait", 32'(state), 32'(ST_FETCH_WAIT));
      data = word;
      read_dn = 1'b1;
      step;
      read_dn = 1'b0;
      data = $urandom;
      m_pc = m_pc + 32'd4;
      m_cmd = word;
      chk("pc_inc", pc, m_pc);
      chk("cmd_latch", command_word, m_cmd);
      chk("rd_state", 32'(state), 32'(ST_READ_DATA));
      cond = take ? ($urandom | 32'd1) : 32'd0;
      repeat ($urandom_range(0, 4)) begin
         exec_done = 1'b1;
         read_dn = 1'b1;
         step;
      end
      exec_done = 1'b0;
      read_dn = 1'b0;
      chk("rd_hold", 32'(state), 32'(ST_READ_DATA));
      next_state = 1'b1;
      step;
      next_state = 1'b0;
      if (!take) begin
         chk("skip_state", 32'(state), 32'(ST_FETCH));
         chk("skip_addr", addr, m_pc);
         return;
      end
      chk("ex_state", 32'(state), 32'(ST_EXECUTE));
      repeat ($urandom_range(0, 4)) begin
         next_state = 1'b1;
         step;
      end
      next_state = 1'b0;
      chk("ex_hold", 32'(state), 32'(ST_EXECUTE));
      exec_done = 1'b1;
      step;
      exec_done = 1'b0;
      chk("wr_state", 32'(state), 32'(ST_WRITE_DATA));
      repeat ($urandom_range(0, 4)) begin
         read_dn = 1'b1;
         exec_done = 1'b1;
         step;
      end
      read_dn = 1'b0;
      exec_done = 1'b0;
      chk("wr_hold", 32'(state), 32'(ST_WRITE_DATA));
      next_state = 1'b1;
      step;
      next_state = 1'b0;
      chk("back_fetch", 32'(state), 32'(ST_FETCH));
      chk("next_addr", addr, m_pc);
      chk("cmd_stable", command_word, m_cmd);
   endtask

   initial begin
      rst = 1'b1;
      data = '0;
      read_dn = 1'b0;
      is_bus_busy = 1'b0;
      next_state = 1'b0;
      cond = '0;
      exec_done = 1'b0;
      w_rst = 1'b1;
      w_data = '0;
      w_read_dn = 1'b0;
      w_busy = 1'b0;
      w_next = 1'b0;
      w_cond = '0;
      w_exec = 1'b0;
      m_pc = 32'h0;
      m_cmd = 32'h0;

      step;
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_pc", pc, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_req", 32'(read_q), 32'd0);
      chk("rst_cmd", command_word, 32'h0);
      chk("rst_base", base_addr, 32'h0);
      chk("rst_halt", 32'(halted), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      step;
      rst = 1'b0;
      data = 32'hDEAD_BEEF;
      read_dn = 1'b1;
      step;
      read_dn = 1'b0;
      chk("base_state", 32'(state), 32'(ST_BASE_ADDR_SET));
      chk("base_addr", base_addr, 32'h100);
      chk("early_rd_cmd", command_word, 32'h0);
      chk("early_rd_pc", pc, 32'h0);
      step;
      chk("base_hold", 32'(state), 32'(ST_BASE_ADDR_SET));
      next_state = 1'b1;
      step;
      next_state = 1'b0;

      fetch_one(32'h0000_0123, 1'b1, 0, 0);
      fetch_one(rand_word(), 1'b0, 0, $urandom_range(0, 3));
      fetch_one(rand_word(), 1'b1, 5, $urandom_range(0, 3));
      for (int n = 0; n < 6; n++)
         fetch_one(rand_word(), 1'($urandom % 2),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      fetch_one(rand_word(), 1'b1, 0, 254);

      chk("tmo_start", 32'(state), 32'(ST_FETCH));
      step;
      chk("tmo_fw", 32'(state), 32'(ST_FETCH_WAIT));
      repeat (254) step;
      chk("tmo_edge_state", 32'(state), 32'(ST_FETCH_WAIT));
      chk("tmo_edge_err", 32'(err), 32'd0);
      step;
      chk("tmo_state", 32'(state), 32'(ST_ERR));
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_halt", 32'(halted), 32'd0);
      read_dn = 1'b1;
      next_state = 1'b1;
      repeat (3) step;
      read_dn = 1'b0;
      next_state = 1'b0;
      chk("err_hold", 32'(state), 32'(ST_ERR));
      chk("err_pc", pc, m_pc);

      rst = 1'b1;
      step;
      chk("rst2_state", 32'(state), 32'(ST_IDLE));
      chk("rst2_err", 32'(err), 32'd0);
      chk("rst2_pc", pc, 32'h0);
      chk("rst2_cmd", command_word, 32'h0);
      rst = 1'b0;
      step;
      next_state = 1'b1;
      step;
      next_state = 1'b0;
      step;
      chk("mid_fw", 32'(state), 32'(ST_FETCH_WAIT));
      rst = 1'b1;
      step;
      chk("mid_rst_state", 32'(state), 32'(ST_IDLE));
      chk("mid_rst_addr", addr, 32'h0);
      rst = 1'b0;
      data = 32'h0000_1234;
      read_dn = 1'b1;
      step;
      read_dn = 1'b0;
      chk("late_rd_state", 32'(state), 32'(ST_BASE_ADDR_SET));
      chk("late_rd_cmd", command_word, 32'h0);
      chk("late_rd_pc", pc, 32'h0);

      w_rst = 1'b1;
      step;
      step;
      w_rst = 1'b0;
      step;
      w_next = 1'b1;
      step;
      w_next = 1'b0;
      chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
      chk("wrap_req", 32'(w_read_q), 32'd1);
      step;
      w_data = 32'hF000_0000;
      w_read_dn = 1'b1;
      step;
      w_read_dn = 1'b0;
      chk("wrap_pc", w_pc, 32'h0);
      chk("wrap_halted", 32'(w_halted), 32'd1);
      chk("wrap_state", 32'(w_state), 32'(ST_HALT));
      chk("wrap_cmd", w_cmd, 32'hF000_0000);
      w_next = 1'b1;
      w_exec = 1'b1;
      w_read_dn = 1'b1;
      repeat (4) step;
      chk("halt_hold", 32'(w_state), 32'(ST_HALT));
      chk("halt_pc", w_pc, 32'h0);
      chk("halt_no_err", 32'(w_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
